// File: rtl/popcount_seq_ctrl.sv
// ---------------------------------------------------------------------------
// popcount_seq_ctrl
//   Computes the population count of a wide vector by stepping one 8-bit
//   popcount datapath across the vector, one byte per clock, and summing the
//   4-bit partial counts into a running total.
//
// Ports
//   clk        in   1            single clock, rising edge
//   rst        in   1            asynchronous, active-high reset
//   in_valid   in   1            requester presents in_data
//   in_ready   out  1            controller is IDLE and can take a vector
//   in_data    in   8*NUM_BYTES  vector to count, byte 0 = bits [7:0]
//   out_valid  out  1            out_count holds a completed result (DONE)
//   out_ready  in   1            consumer accepts the result
//   out_count  out  OUT_WIDTH    popcount of the last accepted vector
//   busy       out  1            high while in RUN or DONE
// ---------------------------------------------------------------------------

// Combinational popcount of one byte.
module popcount_int8 (
    input  logic [7:0] i_a,
    output logic [3:0] o_y
);

    // Sum the eight bits of the byte.
    always_comb begin
        o_y = 4'd0;
        for (int k = 0; k < 8; k++) begin
            o_y = o_y + {3'b000, i_a[k]};
        end
    end

endmodule

module popcount_seq_ctrl #(
    parameter int NUM_BYTES = 4,
    parameter int OUT_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*NUM_BYTES-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_count,
    output logic                   busy
);

    localparam int DW    = 8 * NUM_BYTES;
    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    // The result must hold 8*NUM_BYTES without wrapping.
    if ((2 ** OUT_WIDTH) <= (8 * NUM_BYTES)) begin : g_bad_out_width
        $error("popcount_seq_ctrl: OUT_WIDTH too small for NUM_BYTES");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DW-1:0]        r_shreg;
    logic [IDX_W-1:0]     r_idx;
    logic [OUT_WIDTH-1:0] r_acc;
    logic [OUT_WIDTH-1:0] r_count;
    logic [3:0]           w_pc;
    logic [OUT_WIDTH-1:0] w_sum;
    logic                 w_last;

    // The single shared byte popcount always looks at the low byte.
    popcount_int8 u_pc (
        .i_a (r_shreg[7:0]),
        .o_y (w_pc)
    );

    assign w_sum  = r_acc + OUT_WIDTH'(w_pc);
    assign w_last = (r_idx == IDX_W'(NUM_BYTES - 1));

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                // Returning to IDLE (not straight to RUN) keeps a consume
                // and a new acceptance from sharing one cycle.
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: load on acceptance, then shift/accumulate one byte per edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg <= '0;
            r_idx   <= '0;
            r_acc   <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_shreg <= in_data;
                        r_idx   <= '0;
                        r_acc   <= '0;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_sum;
                    r_shreg <= r_shreg >> 4'd8;
                    r_idx   <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_count <= w_sum;
                    end
                end
                S_DONE: begin
                    r_idx <= r_idx;
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

    assign out_count = r_count;

endmodule

// File: tb/tb_popcount_seq_ctrl.sv
// Bench for popcount_seq_ctrl: directed scenarios on a 4-byte instance and
// randomized traffic on 4-byte and 1-byte instances, checked against a
// $countones reference with a queue of pending results.
module tb_popcount_seq_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 4-byte instance
    logic        iv4, ir4, ov4, or4, busy4;
    logic [31:0] id4;
    logic [5:0]  oc4;
    // 1-byte instance
    logic        iv1, ir1, ov1, or1, busy1;
    logic [7:0]  id1;
    logic [3:0]  oc1;

    popcount_seq_ctrl #(.NUM_BYTES(4), .OUT_WIDTH(6)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
        .out_valid(ov4), .out_ready(or4), .out_count(oc4), .busy(busy4)
    );

    popcount_seq_ctrl #(.NUM_BYTES(1), .OUT_WIDTH(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_count(oc1), .busy(busy1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Send one vector to dut4 from IDLE, expect the result 4 cycles later,
    // hold out_ready low for 'hold' cycles in DONE, then consume it.
    task automatic send_wait(input logic [31:0] d, input int exp_cnt, input int hold, input string tag);
        int n;
        check_eq({tag, "_idle_ready"}, ir4, 1);
        iv4 = 1'b1; id4 = d; or4 = (hold == 0);
        @(negedge clk);
        iv4 = 1'b0; id4 = $urandom;
        check_eq({tag, "_ready_drop"}, ir4, 0);
        check_eq({tag, "_busy_run"}, busy4, 1);
        check_eq({tag, "_no_early_valid"}, ov4, 0);
        n = 0;
        while (!ov4 && n < 20) begin
            @(negedge clk);
            n++;
            if (!ov4) check_eq({tag, "_busy_mid"}, busy4, 1);
        end
        check_eq({tag, "_latency"}, n, 4);
        check_eq({tag, "_count"}, oc4, exp_cnt);
        check_eq({tag, "_busy_done"}, busy4, 1);
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                check_eq({tag, "_hold_valid"}, ov4, 1);
                check_eq({tag, "_hold_count"}, oc4, exp_cnt);
            end
            or4 = 1'b1;
        end
        @(negedge clk);
        check_eq({tag, "_valid_clear"}, ov4, 0);
        check_eq({tag, "_ready_back"}, ir4, 1);
        check_eq({tag, "_busy_clear"}, busy4, 0);
        check_eq({tag, "_count_kept"}, oc4, exp_cnt);
        or4 = 1'b0;
    endtask

    // Random traffic with random out_ready on one instance (sel=1 -> 1-byte).
    task automatic rand_traffic(input int sel, input int ncyc);
        int          exp_q[$];
        logic        vi, ro, ir, ov, by, drain;
        logic [31:0] d, oc;
        for (int k = 0; k < ncyc + 60; k++) begin
            ir = sel ? ir1 : ir4;
            ov = sel ? ov1 : ov4;
            by = sel ? busy1 : busy4;
            oc = sel ? {28'd0, oc1} : {26'd0, oc4};
            drain = (k >= ncyc);
            vi = !drain && ($urandom_range(0, 3) != 0);
            ro = drain || ($urandom_range(0, 1) == 1);
            d  = $urandom;
            if (sel != 0) d = d & 32'h0000_00FF;
            check_eq("rand_busy_vs_ready", by, !ir);
            if (ov && ro) begin
                if (exp_q.size() == 0) check_eq("rand_unexpected_result", exp_q.size(), 1);
                else check_eq("rand_count", oc, exp_q.pop_front());
            end
            if (ir && vi) exp_q.push_back($countones(d));
            if (sel != 0) begin
                iv1 = vi; id1 = d[7:0]; or1 = ro;
            end else begin
                iv4 = vi; id4 = d; or4 = ro;
            end
            @(negedge clk);
        end
        check_eq("rand_leftover", exp_q.size(), 0);
        iv1 = 1'b0; or1 = 1'b0; iv4 = 1'b0; or4 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cyc[$];
        int res[$];
        logic saw_valid;

        rst = 1'b1;
        iv4 = 1'b0; or4 = 1'b0; id4 = 32'd0;
        iv1 = 1'b0; or1 = 1'b0; id1 = 8'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("reset_in_ready", ir4, 1);
        check_eq("reset_out_valid", ov4, 0);
        check_eq("reset_out_count", oc4, 0);
        check_eq("reset_busy", busy4, 0);
        check_eq("reset_in_ready_nb1", ir1, 1);

        send_wait(32'hFFFF_FFFF, 32, 0, "all_ones");
        send_wait(32'h0000_0000, 0, 0, "all_zero");
        send_wait(32'h8001_0F03, 8, 10, "stall");

        // in_valid held high: back-to-back acceptance spacing.
        iv4 = 1'b1; id4 = 32'h0000_00FF; or4 = 1'b1;
        for (int k = 0; k < 30 && res.size() < 2; k++) begin
            if (acc_cyc.size() >= 2) iv4 = 1'b0;
            else if (acc_cyc.size() == 1) id4 = 32'h0101_0101;
            if (ov4 && or4) res.push_back(oc4);
            if (ir4 && iv4) acc_cyc.push_back(cyc);
            @(negedge clk);
        end
        iv4 = 1'b0; or4 = 1'b0;
        check_eq("b2b_results", res.size(), 2);
        check_eq("b2b_accepts", acc_cyc.size(), 2);
        if (res.size() >= 2) begin
            check_eq("b2b_first", res[0], 8);
            check_eq("b2b_second", res[1], 4);
        end
        if (acc_cyc.size() >= 2) check_eq("b2b_spacing", acc_cyc[1] - acc_cyc[0], 6);
        @(negedge clk);

        // Asynchronous reset mid-RUN after two bytes.
        iv4 = 1'b1; id4 = 32'hFFFF_FFFF;
        @(negedge clk);
        iv4 = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("abort_in_ready", ir4, 1);
        check_eq("abort_out_valid", ov4, 0);
        check_eq("abort_busy", busy4, 0);
        check_eq("abort_out_count", oc4, 0);
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            saw_valid = saw_valid | ov4;
        end
        check_eq("abort_no_result", saw_valid, 0);
        send_wait(32'h0000_0007, 3, 0, "after_abort");

        rand_traffic(0, 600);
        rand_traffic(1, 300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
